// File: rtl/mel_log_compress.sv
// Final log stage of the log-mel pipeline: queues mel-band energies and returns
// log2(energy) as signed fixed point, one fractional bit per squaring iteration.
module mel_log_compress #(
  parameter int unsigned I_BW       = 30,
  parameter int unsigned O_BW       = 14,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned MANT_BW    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GN_BW      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [I_BW-1:0]  data_i,
  input  logic [GN_BW-1:0] in_group_num,
  output logic             do_en,
  output logic [O_BW-1:0]  data_o,
  output logic [GN_BW-1:0] out_group_num,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned PTR_BW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_BW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_BW = I_BW + GN_BW;
  localparam int unsigned P_BW   = $clog2(I_BW);
  localparam int unsigned K_BW   = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
  localparam int unsigned SQ_BW  = 2 * MANT_BW;
  localparam logic [O_BW-1:0] CLAMP = {1'b1, {(O_BW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_OUT} state_e;

  state_e              state_q, state_d;
  logic [ENT_BW-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_BW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0]   count_q, count_d;
  logic [I_BW-1:0]     x_q, x_d;
  logic [GN_BW-1:0]    gn_q, gn_d;
  logic [P_BW-1:0]     p_q, p_d;
  logic [MANT_BW-1:0]  m_q, m_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [K_BW-1:0]     k_q, k_d;
  logic                do_en_q, do_en_d;
  logic [O_BW-1:0]     data_o_q, data_o_d;
  logic [GN_BW-1:0]    ogn_q, ogn_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;

  logic                pop_c, push_c;
  logic [ENT_BW-1:0]   head_c;
  logic                x_nonpos_c;
  logic [P_BW-1:0]     msb_c;
  logic [I_BW-1:0]     x_norm_c;
  logic [MANT_BW-1:0]  mant_init_c;
  logic [SQ_BW-1:0]    sq_c;
  logic                unused_bits_c;

  // FIFO control: a push into a full FIFO is still accepted when the head pops this cycle
  always_comb begin
    pop_c      = (state_q == S_IDLE) && (count_q != '0);
    push_c     = di_en && ((count_q < CNT_BW'(FIFO_DEPTH)) || pop_c);
    head_c     = mem_q[rd_ptr_q];
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_BW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_BW'(1) : rd_ptr_q;
    count_d    = count_q + CNT_BW'(push_c) - CNT_BW'(pop_c);
    overflow_d = overflow_q | (di_en & ~push_c);
  end

  // Normalisation: leading-one position and left-aligned truncated mantissa
  always_comb begin
    x_nonpos_c = x_q[I_BW-1] || (x_q == '0);
    msb_c      = '0;
    for (int unsigned i = 0; i < I_BW - 1; i++) begin
      if (x_q[i]) msb_c = P_BW'(i);
    end
    x_norm_c    = x_q << (P_BW'(I_BW - 1) - msb_c);
    mant_init_c = x_norm_c[I_BW-1 -: MANT_BW];
    sq_c        = SQ_BW'(m_q) * SQ_BW'(m_q);
  end

  assign unused_bits_c = ^{sq_c[SQ_BW-MANT_BW-2:0], x_norm_c[I_BW-MANT_BW-1:0]};

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    gn_d     = gn_q;
    p_d      = p_q;
    m_d      = m_q;
    frac_d   = frac_q;
    k_d      = k_q;
    do_en_d  = 1'b0;
    data_o_d = data_o_q;
    ogn_d    = ogn_q;
    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          x_d     = head_c[ENT_BW-1 -: I_BW];
          gn_d    = head_c[GN_BW-1:0];
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (x_nonpos_c) begin
          data_o_d = CLAMP;
          ogn_d    = gn_q;
          do_en_d  = 1'b1;
          state_d  = S_OUT;
        end else begin
          p_d     = msb_c;
          m_d     = mant_init_c;
          frac_d  = '0;
          k_d     = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // Square >= 2.0 yields a one bit and renormalises by halving
        m_d    = sq_c[SQ_BW-1] ? sq_c[SQ_BW-1 -: MANT_BW] : sq_c[SQ_BW-2 -: MANT_BW];
        frac_d = (frac_q << 1) | FRAC_BITS'(sq_c[SQ_BW-1]);
        k_d    = k_q + K_BW'(1);
        if (k_q == K_BW'(FRAC_BITS - 1)) begin
          data_o_d = (O_BW'(p_q) << FRAC_BITS) | O_BW'(frac_d);
          ogn_d    = gn_q;
          do_en_d  = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= {data_i, in_group_num};
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      x_q        <= '0;
      gn_q       <= '0;
      p_q        <= '0;
      m_q        <= '0;
      frac_q     <= '0;
      k_q        <= '0;
      do_en_q    <= 1'b0;
      data_o_q   <= '0;
      ogn_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      x_q        <= x_d;
      gn_q       <= gn_d;
      p_q        <= p_d;
      m_q        <= m_d;
      frac_q     <= frac_d;
      k_q        <= k_d;
      do_en_q    <= do_en_d;
      data_o_q   <= data_o_d;
      ogn_q      <= ogn_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign do_en         = do_en_q;
  assign data_o        = data_o_q;
  assign out_group_num = ogn_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_mel_log_compress.sv
// Self-checking bench for mel_log_compress: directed latency/value cases plus
// randomized traffic against a timing-aware arithmetic reference model.
module tb_mel_log_compress;

  localparam int unsigned I_BW = 30;
  localparam int unsigned O_BW = 14;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned GN_BW = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             di_en;
  logic [I_BW-1:0]  data_i;
  logic [GN_BW-1:0] in_group_num;
  logic             do_en;
  logic [O_BW-1:0]  data_o;
  logic [GN_BW-1:0] out_group_num;
  logic             busy;
  logic             overflow;

  mel_log_compress dut (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i), .in_group_num(in_group_num),
    .do_en(do_en), .data_o(data_o), .out_group_num(out_group_num),
    .busy(busy), .overflow(overflow)
  );

  typedef struct {
    logic [O_BW-1:0]  d;
    logic [GN_BW-1:0] g;
    int               c;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  int   acc_in[$];
  int   acc_start[$];
  int   last_done = -100;
  logic exp_ovf = 1'b0;
  logic busy_at[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_at[cyc] = busy;
    if (!rst && do_en) obs_q.push_back('{data_o, out_group_num, cyc});
  end

  // Reference: log2 by repeated squaring of a truncated Q1.15 mantissa
  function automatic logic [O_BW-1:0] ref_log(input logic [I_BW-1:0] x);
    longint v, m, sq;
    int p, f;
    v = longint'($signed(x));
    if (v <= 0) return {1'b1, {(O_BW-1){1'b0}}};
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    if (p >= 15) m = v >> (p - 15);
    else m = v << (15 - p);
    f = 0;
    for (int k = 0; k < FRAC_BITS; k++) begin
      sq = m * m;
      if (sq >= (64'sd1 <<< 31)) begin f = f * 2 + 1; m = sq >> 16; end
      else begin f = f * 2; m = sq >> 15; end
    end
    return O_BW'((p << FRAC_BITS) + f);
  endfunction

  task automatic model_reset();
    exp_q.delete(); obs_q.delete(); acc_in.delete(); acc_start.delete();
    last_done = -100; exp_ovf = 1'b0;
  endtask

  // Drive one sample and predict acceptance, result and do_en cycle
  task automatic drive(input logic [I_BW-1:0] x, input logic [GN_BW-1:0] g);
    int cnt, start;
    bit pop_now;
    @(posedge clk); #1;
    di_en = 1'b1; data_i = x; in_group_num = g;
    cnt = 0; pop_now = 0;
    foreach (acc_in[j]) begin
      if (acc_in[j] < cyc && acc_start[j] >= cyc) cnt++;
      if (acc_start[j] == cyc) pop_now = 1;
    end
    if (cnt < 4 || pop_now) begin
      start = (cyc + 1 > last_done + 1) ? cyc + 1 : last_done + 1;
      last_done = start + (($signed(x) <= 0) ? 2 : 10);
      acc_in.push_back(cyc);
      acc_start.push_back(start);
      exp_q.push_back('{ref_log(x), g, last_done});
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; di_en = 1'b0; end
  endtask

  task automatic settle();
    int guard = 0;
    while (cyc <= last_done + 1 && guard < 2000) begin idle(1); guard++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; di_en = 1'b0; data_i = '0; in_group_num = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (do_en !== 1'b0) begin errors++; $display("FAIL reset_do_en: got %b expected 0", do_en); end
    if (data_o !== '0) begin errors++; $display("FAIL reset_data_o: got %0d expected 0", data_o); end
    if (out_group_num !== '0) begin errors++; $display("FAIL reset_gn: got %0d expected 0", out_group_num); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(posedge clk); #1; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [I_BW-1:0] vals [5];
    logic [O_BW-1:0] lits [5];
    rec_t o;
    int c0;
    vals = '{30'd1, 30'd2, 30'd268435456, 30'd3, 30'd536870911};
    lits = '{14'd0, 14'd256, 14'd7168, 14'd405, 14'd7423};
    for (int i = 0; i < 5; i++) begin
      drive(vals[i], GN_BW'(i + 1));
      c0 = cyc;
      settle();
      checks++;
      if (obs_q.size() != 1) begin
        errors++; $display("FAIL single_count[%0d]: got %0d outputs expected 1", i, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        checks += 2;
        if (o.d !== lits[i] || o.g !== GN_BW'(i + 1)) begin
          errors++; $display("FAIL single_value[%0d]: got %0d/g%0d expected %0d/g%0d", i, o.d, o.g, lits[i], i + 1);
        end
        if (o.c !== c0 + 11) begin
          errors++; $display("FAIL single_latency[%0d]: got %0d cycles expected 11", i, o.c - c0);
        end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_zero_neg();
    logic [I_BW-1:0] vals [2];
    rec_t o;
    int c0;
    vals = '{'0, I_BW'(-5)};
    for (int i = 0; i < 2; i++) begin
      drive(vals[i], GN_BW'(10 + i));
      c0 = cyc;
      settle();
      checks++;
      if (obs_q.size() != 1) begin
        errors++; $display("FAIL clamp_count[%0d]: got %0d outputs expected 1", i, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        checks += 2;
        if ($signed(o.d) !== -14'sd8192 || o.g !== GN_BW'(10 + i)) begin
          errors++; $display("FAIL clamp_value[%0d]: got %0d/g%0d expected -8192/g%0d", i, $signed(o.d), o.g, 10 + i);
        end
        if (o.c !== c0 + 3) begin
          errors++; $display("FAIL clamp_latency[%0d]: got %0d cycles expected 3", i, o.c - c0);
        end
      end
      checks += 2;
      if (busy_at[c0 + 3] !== 1'b1) begin errors++; $display("FAIL clamp_busy_at_out[%0d]: got %b expected 1", i, busy_at[c0 + 3]); end
      if (busy_at[c0 + 4] !== 1'b0) begin errors++; $display("FAIL clamp_busy_after[%0d]: got %b expected 0", i, busy_at[c0 + 4]); end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    rec_t o;
    int c0;
    drive(30'd2, 7'd0);
    c0 = cyc;
    for (int i = 1; i < 5; i++) drive(I_BW'(2 << i), GN_BW'(i));
    idle(1);
    settle();
    checks += 2;
    if (obs_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 5", obs_q.size()); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      checks++;
      if (o.d !== O_BW'(256 * (i + 1)) || o.g !== GN_BW'(i) || o.c !== c0 + 11 * (i + 1)) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got %0d/g%0d@+%0d expected %0d/g%0d@+%0d",
                 i, o.d, o.g, o.c - c0, 256 * (i + 1), i, 11 * (i + 1));
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rec_t o, e;
    logic [I_BW-1:0] x;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: x = I_BW'($urandom);
        1: x = I_BW'($urandom_range(0, 20));
        2: x = I_BW'(1) << $urandom_range(0, 28);
        default: x = I_BW'($urandom_range(1, 65535));
      endcase
      drive(x, GN_BW'($urandom));
      idle($urandom_range(0, 14));
    end
    settle();
    checks += 2;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_overflow: got %b expected %b", overflow, exp_ovf); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.d !== e.d || o.g !== e.g || o.c !== e.c) begin
        errors++;
        $display("FAIL rand_out: got %0d/g%0d@%0d expected %0d/g%0d@%0d",
                 $signed(o.d), o.g, o.c, $signed(e.d), e.g, e.c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    rec_t o, e;
    for (int i = 0; i < 6; i++) drive(I_BW'(1000 + 37 * i), GN_BW'(20 + i));
    idle(1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    settle();
    checks += 3;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    if (obs_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d outputs expected 5", obs_q.size()); end
    if (exp_q.size() != obs_q.size()) begin
      errors++; $display("FAIL ovf_model_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.d !== e.d || o.g !== e.g || o.c !== e.c) begin
        errors++;
        $display("FAIL ovf_out: got %0d/g%0d@%0d expected %0d/g%0d@%0d", o.d, o.g, o.c, e.d, e.g, e.c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rec_t o;
    int c0;
    for (int i = 0; i < 3; i++) drive(I_BW'(77 + i), GN_BW'(40 + i));
    idle(4);
    rst = 1'b1;
    #1;
    checks += 5;
    if (do_en !== 1'b0) begin errors++; $display("FAIL rstmid_do_en: got %b expected 0", do_en); end
    if (data_o !== '0) begin errors++; $display("FAIL rstmid_data_o: got %0d expected 0", data_o); end
    if (out_group_num !== '0) begin errors++; $display("FAIL rstmid_gn: got %0d expected 0", out_group_num); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b expected 0", overflow); end
    idle(2);
    rst = 1'b0;
    model_reset();
    idle(20);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_output: got %0d outputs expected 0", obs_q.size()); end
    obs_q.delete();
    drive(30'd4, 7'd99);
    c0 = cyc;
    settle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rstmid_fresh_count: got %0d outputs expected 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.d !== 14'd512 || o.g !== 7'd99 || o.c !== c0 + 11) begin
        errors++; $display("FAIL rstmid_fresh: got %0d/g%0d@+%0d expected 512/g99@+11", o.d, o.g, o.c - c0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_neg();
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
